// File: rtl/sram_bram_responder_if.sv
// rtl/sram_bram_responder_if.sv - SRAM-like request/response bus between core master and memory responder
interface sram_bram_responder_if;
   logic        req;
   logic        wr;
   logic [31:0] addr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, addr, size, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, addr, size, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_bram_responder.sv
// rtl/sram_bram_responder.sv - in-order fixed-latency SRAM-bus responder backed by a single-port block RAM
module sram_bram_responder #(
   parameter int ADDR_W  = 14,
   parameter int LATENCY = 1,
   parameter int DEPTH   = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   sram_bram_responder_if.slave  bus,
   input  logic                  addr_stall_i,
   output logic                  mem_en_o,
   output logic [3:0]            mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Outstanding-request counter and response pipeline control bits.
   // Index 0 of the pipeline is stage 1 (the cycle the RAM output is valid).
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [LATENCY-1:0]       valid_q, valid_d;
   logic [LATENCY-1:0]       is_wr_q, is_wr_d;
   logic [LATENCY-1:0][31:0] stage_data;
   logic                     accept;
   logic                     resp_fire;

   // Address bits outside the RAM window and the size field carry no information here.
   logic unused_bits;
   assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:ADDR_W+2]};

   // Acceptance is purely a function of reset, throttle and occupancy, never of req.
   assign bus.addr_ok = !rst_i && !addr_stall_i && (cnt_q < DEPTH_C);
   assign accept      = bus.req && bus.addr_ok;

   // The RAM is accessed in the acceptance cycle, so RAM order equals acceptance order
   // and a read right after a write to the same word sees the new data.
   assign mem_en_o    = accept;
   assign mem_we_o    = (accept && bus.wr) ? bus.wstrb : 4'b0000;
   assign mem_addr_o  = bus.addr[ADDR_W+1:2];
   assign mem_wdata_o = bus.wdata;

   // Stage 1 data is the RAM output register itself; later stages copy it along.
   assign stage_data[0] = mem_rdata_i;

   generate
      for (genvar s = 1; s < LATENCY; s++) begin : g_data
         logic [31:0] data_q;

         // Carry read data one stage further down the response pipeline.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               data_q <= '0;
            end else begin
               data_q <= stage_data[s-1];
            end
         end

         assign stage_data[s] = data_q;
      end
   endgenerate

   assign resp_fire   = valid_q[LATENCY-1];
   assign bus.data_ok = resp_fire;
   assign bus.rdata   = (resp_fire && !is_wr_q[LATENCY-1]) ? stage_data[LATENCY-1] : 32'd0;

   // Next state: shift the valid/kind pipeline and track accepted-but-unanswered requests.
   always_comb begin
      valid_d    = '0;
      is_wr_d    = '0;
      cnt_d      = cnt_q;
      valid_d[0] = accept;
      is_wr_d[0] = bus.wr;
      for (int i = 1; i < LATENCY; i++) begin
         valid_d[i] = valid_q[i-1];
         is_wr_d[i] = is_wr_q[i-1];
      end
      case ({accept, resp_fire})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state; reset drops every in-flight response immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         valid_q <= '0;
         is_wr_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         is_wr_q <= is_wr_d;
      end
   end

endmodule

// File: tb/tb_sram_bram_responder.sv
// tb/tb_sram_bram_responder.sv - randomized and directed bench for sram_bram_responder over four latency/depth configurations
module tb_sram_bram_responder;

   localparam int AW   = 8;
   localparam int NCFG = 4;

   typedef struct {
      int          due;
      logic [31:0] data;
   } resp_t;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        req   = 1'b0;
   logic        wr    = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic [1:0]  size  = 2'b10;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i, input int g);
      return (32'(i) * 32'h9E3779B1) ^ (32'h5A5A0000 + 32'(g));
   endfunction

   task automatic check(input string tag, input int cfg, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cfg%0d cyc=%0d observed=%h expected=%h", tag, cfg, cyc, obs, exp);
      end
   endtask

   generate
      for (genvar g = 0; g < NCFG; g++) begin : g_cfg
         localparam int LAT = (g == 0) ? 1 : (g == 3) ? 4 : 3;
         localparam int DEP = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 2;

         sram_bram_responder_if bus();

         logic          mem_en;
         logic [3:0]    mem_we;
         logic [AW-1:0] mem_addr;
         logic [31:0]   mem_wdata;
         logic [31:0]   mem_rdata;
         logic [31:0]   ram     [2**AW];
         logic [31:0]   ref_mem [2**AW];
         resp_t         pend[$];

         assign bus.req   = req;
         assign bus.wr    = wr;
         assign bus.addr  = addr;
         assign bus.size  = size;
         assign bus.wstrb = wstrb;
         assign bus.wdata = wdata;

         sram_bram_responder #(.ADDR_W(AW), .LATENCY(LAT), .DEPTH(DEP)) dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .bus          (bus),
            .addr_stall_i (stall),
            .mem_en_o     (mem_en),
            .mem_we_o     (mem_we),
            .mem_addr_o   (mem_addr),
            .mem_wdata_o  (mem_wdata),
            .mem_rdata_i  (mem_rdata)
         );

         initial begin
            mem_rdata = '0;
            for (int i = 0; i < 2**AW; i++) begin
               ram[i]     = init_word(i, g);
               ref_mem[i] = init_word(i, g);
            end
         end

         // Read-first single-port block RAM with byte enables.
         always @(posedge clk) begin
            if (mem_en) begin
               mem_rdata <= ram[mem_addr];
               for (int b = 0; b < 4; b++)
                  if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end

         // Reference model: a word array plus a queue of responses with due cycles.
         always @(negedge clk) begin : b_model
            logic        exp_ok;
            logic        exp_dok;
            logic        acc;
            logic [31:0] exp_rd;
            int          w;
            exp_ok  = !rst && !stall && (pend.size() < DEP);
            exp_dok = !rst && (pend.size() > 0) && (pend[0].due == cyc);
            exp_rd  = exp_dok ? pend[0].data : 32'd0;
            acc     = req && exp_ok;
            check("addr_ok", g, {31'd0, bus.addr_ok}, {31'd0, exp_ok});
            check("data_ok", g, {31'd0, bus.data_ok}, {31'd0, exp_dok});
            check("rdata",   g, bus.rdata, exp_rd);
            check("mem_en",  g, {31'd0, mem_en}, {31'd0, acc});
            check("mem_we",  g, {28'd0, mem_we}, {28'd0, (acc && wr) ? wstrb : 4'b0000});
            if (acc) begin
               check("mem_addr",  g, {{(32-AW){1'b0}}, mem_addr}, {{(32-AW){1'b0}}, addr[AW+1:2]});
               check("mem_wdata", g, mem_wdata, wdata);
            end
            if (exp_dok) void'(pend.pop_front());
            if (rst) begin
               pend.delete();
            end else if (acc) begin
               w = int'(addr[AW+1:2]);
               if (wr) begin
                  for (int b = 0; b < 4; b++)
                     if (wstrb[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
                  pend.push_back('{cyc + LAT, 32'd0});
               end else begin
                  pend.push_back('{cyc + LAT, ref_mem[w]});
               end
            end
         end
      end
   endgenerate

   task automatic step(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
      req = r; wr = w; addr = a; wstrb = s; wdata = d;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Write then back-to-back read of the same word.
      step(1'b1, 1'b1, 32'h0000_0100, 4'b1111, 32'hDEADBEEF);
      step(1'b1, 1'b0, 32'h0000_0100, 4'b0000, 32'd0);
      idle(6);

      // Byte-lane write over a full word, then an all-zero strobe write.
      step(1'b1, 1'b1, 32'h0000_0040, 4'b1111, 32'h11223344);
      idle(5);
      step(1'b1, 1'b1, 32'h0000_0040, 4'b0010, 32'h0000AB00);
      idle(5);
      step(1'b1, 1'b0, 32'h0000_0040, 4'b0000, 32'd0);
      idle(5);
      step(1'b1, 1'b1, 32'h0000_0041, 4'b0000, 32'hFFFFFFFF);
      idle(5);
      step(1'b1, 1'b0, 32'hF000_0042, 4'b0000, 32'd0);
      idle(6);

      // Consecutive reads for pipelined throughput.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(4 * i), 4'd0, 32'd0);
      idle(6);

      // Request held high: occupancy limits acceptance.
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'(16 + 4 * i), 4'd0, 32'd0);
      idle(6);

      // Throttle with request pending, then release.
      stall = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0000_0080, 4'd0, 32'd0);
      stall = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0000_0080, 4'd0, 32'd0);
      idle(6);

      // Reset with reads in flight; they must never be answered.
      step(1'b1, 1'b0, 32'h0000_0010, 4'd0, 32'd0);
      step(1'b1, 1'b0, 32'h0000_0014, 4'd0, 32'd0);
      idle(1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      step(1'b1, 1'b0, 32'h0000_0100, 4'd0, 32'd0);
      idle(8);

      // Randomized traffic over a small word window with aliased upper bits.
      for (int i = 0; i < 800; i++) begin
         a = $urandom;
         a[AW+1:2] = AW'($urandom_range(0, 15));
         stall = ($urandom_range(0, 99) < 15);
         rst   = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 40, a,
              4'($urandom), $urandom);
         rst = 1'b0;
      end
      stall = 1'b0;
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
